// File: rtl/controlador_mc_param.sv
// controlador_mc_param: multicycle MIPS control unit (Moore FSM).
// Sequences fetch, memory wait states, decode and execution of R-type,
// lw, sw, addi, beq, j and jr. All outputs decode from the current state.
// Optional feature: define CONTROLADOR_EXC_EN to route illegal opcodes
// through a one-cycle exception state (EPC write + exception vector).
module controlador_mc_param #(
  parameter int MEM_WAIT = 2,
  parameter int STATE_W  = 5
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         InstrArit,
  output logic               PCEsc,
  output logic               PCEscCond,
  output logic [1:0]         PCFonte,
  output logic               CtrMem,
  output logic               IouD,
  output logic               IREsc,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemParaReg,
  output logic               ULAFonteA,
  output logic [1:0]         ULAFonteB,
  output logic [1:0]         ULAOp,
  output logic               EPCEsc,
  output logic               ExcVetor,
  output logic [STATE_W-1:0] state
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] FWAIT  = 4'd1;
  localparam logic [3:0] IRLOAD = 4'd2;
  localparam logic [3:0] DECODE = 4'd3;
  localparam logic [3:0] EXECR  = 4'd4;
  localparam logic [3:0] WBR    = 4'd5;
  localparam logic [3:0] ADDR   = 4'd6;
  localparam logic [3:0] WBI    = 4'd7;
  localparam logic [3:0] MEMRD  = 4'd8;
  localparam logic [3:0] MWAIT  = 4'd9;
  localparam logic [3:0] WBLW   = 4'd10;
  localparam logic [3:0] MEMWR  = 4'd11;
  localparam logic [3:0] BEQ    = 4'd12;
  localparam logic [3:0] JUMP   = 4'd13;
  localparam logic [3:0] JR     = 4'd14;
  localparam logic [3:0] EXC    = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Wait states exit on the last count, so they last exactly MEM_WAIT cycles.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  logic [3:0] state_q;
  logic [3:0] state_nxt;
  logic [3:0] cnt_q;

  assign state = STATE_W'(state_q);

  // State register; reset returns to FETCH at once, even mid-instruction.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= FETCH;
    else        state_q <= state_nxt;
  end

  // Wait counter: cleared on any state change (hence on wait-state entry),
  // counts up while the FSM dwells in a wait state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                   cnt_q <= 4'd0;
    else if (state_nxt != state_q) cnt_q <= 4'd0;
    else                          cnt_q <= cnt_q + 4'd1;
  end

  // Next-state logic; unknown codes fall back to FETCH.
  always_comb begin
    state_nxt = FETCH;
    case (state_q)
      FETCH:  state_nxt = FWAIT;
      FWAIT:  state_nxt = (cnt_q == WAIT_LAST) ? IRLOAD : FWAIT;
      IRLOAD: state_nxt = DECODE;
      DECODE: begin
        case (OpCode)
          OP_RTYPE: state_nxt = (InstrArit == FN_JR) ? JR : EXECR;
          OP_LW, OP_SW, OP_ADDI: state_nxt = ADDR;
          OP_BEQ:   state_nxt = BEQ;
          OP_J:     state_nxt = JUMP;
`ifdef CONTROLADOR_EXC_EN
          default:  state_nxt = EXC;
`else
          default:  state_nxt = FETCH;
`endif
        endcase
      end
      EXECR:  state_nxt = WBR;
      WBR:    state_nxt = FETCH;
      ADDR: begin
        // IR holds the opcode stable through the whole instruction.
        case (OpCode)
          OP_LW:   state_nxt = MEMRD;
          OP_SW:   state_nxt = MEMWR;
          OP_ADDI: state_nxt = WBI;
          default: state_nxt = FETCH;
        endcase
      end
      WBI:    state_nxt = FETCH;
      MEMRD:  state_nxt = MWAIT;
      MWAIT:  state_nxt = (cnt_q == WAIT_LAST) ? WBLW : MWAIT;
      WBLW:   state_nxt = FETCH;
      MEMWR:  state_nxt = FETCH;
      BEQ:    state_nxt = FETCH;
      JUMP:   state_nxt = FETCH;
      JR:     state_nxt = FETCH;
`ifdef CONTROLADOR_EXC_EN
      EXC:    state_nxt = FETCH;
`endif
      default: state_nxt = FETCH;
    endcase
  end

  // Moore output decode: defaults are all-zero with the ULA idle.
  always_comb begin
    PCEsc      = 1'b0;
    PCEscCond  = 1'b0;
    PCFonte    = 2'b00;
    CtrMem     = 1'b0;
    IouD       = 1'b0;
    IREsc      = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemParaReg = 1'b0;
    ULAFonteA  = 1'b0;
    ULAFonteB  = 2'b00;
    ULAOp      = 2'b11;
    EPCEsc     = 1'b0;
    ExcVetor   = 1'b0;
    case (state_q)
      IRLOAD: begin
        IREsc = 1'b1; PCEsc = 1'b1; ULAFonteB = 2'b01; ULAOp = 2'b00;
      end
      DECODE: begin
        ULAFonteB = 2'b11; ULAOp = 2'b00;
      end
      EXECR: begin
        ULAFonteA = 1'b1; ULAOp = 2'b10;
      end
      WBR: begin
        RegWrite = 1'b1; RegDst = 1'b1;
      end
      ADDR: begin
        ULAFonteA = 1'b1; ULAFonteB = 2'b10; ULAOp = 2'b00;
      end
      WBI:   RegWrite = 1'b1;
      MEMRD: IouD = 1'b1;
      MWAIT: IouD = 1'b1;
      WBLW: begin
        RegWrite = 1'b1; MemParaReg = 1'b1;
      end
      MEMWR: begin
        IouD = 1'b1; CtrMem = 1'b1;
      end
      BEQ: begin
        ULAFonteA = 1'b1; ULAOp = 2'b01; PCEscCond = 1'b1; PCFonte = 2'b01;
      end
      JUMP: begin
        PCEsc = 1'b1; PCFonte = 2'b10;
      end
      JR: begin
        PCEsc = 1'b1; PCFonte = 2'b11;
      end
`ifdef CONTROLADOR_EXC_EN
      EXC: begin
        EPCEsc = 1'b1; PCEsc = 1'b1; ExcVetor = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controlador_mc_param.sv
// Testbench for controlador_mc_param: two instances (MEM_WAIT=2 and 3),
// scoreboard of expected per-cycle states with an independent output table.
module tb_controlador_mc_param;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [5:0] OpCode;
  logic [5:0] InstrArit;

  logic       PCEsc      [2];
  logic       PCEscCond  [2];
  logic [1:0] PCFonte    [2];
  logic       CtrMem     [2];
  logic       IouD       [2];
  logic       IREsc      [2];
  logic       RegWrite   [2];
  logic       RegDst     [2];
  logic       MemParaReg [2];
  logic       ULAFonteA  [2];
  logic [1:0] ULAFonteB  [2];
  logic [1:0] ULAOp      [2];
  logic       EPCEsc     [2];
  logic       ExcVetor   [2];
  logic [4:0] st         [2];

  int checks   = 0;
  int failures = 0;
  int expq[$];

  always #5 Clock = ~Clock;

  controlador_mc_param #(.MEM_WAIT(2), .STATE_W(5)) dut_m2 (
    .Clock(Clock), .Reset(Reset), .OpCode(OpCode), .InstrArit(InstrArit),
    .PCEsc(PCEsc[0]), .PCEscCond(PCEscCond[0]), .PCFonte(PCFonte[0]),
    .CtrMem(CtrMem[0]), .IouD(IouD[0]), .IREsc(IREsc[0]),
    .RegWrite(RegWrite[0]), .RegDst(RegDst[0]), .MemParaReg(MemParaReg[0]),
    .ULAFonteA(ULAFonteA[0]), .ULAFonteB(ULAFonteB[0]), .ULAOp(ULAOp[0]),
    .EPCEsc(EPCEsc[0]), .ExcVetor(ExcVetor[0]), .state(st[0])
  );

  controlador_mc_param #(.MEM_WAIT(3), .STATE_W(5)) dut_m3 (
    .Clock(Clock), .Reset(Reset), .OpCode(OpCode), .InstrArit(InstrArit),
    .PCEsc(PCEsc[1]), .PCEscCond(PCEscCond[1]), .PCFonte(PCFonte[1]),
    .CtrMem(CtrMem[1]), .IouD(IouD[1]), .IREsc(IREsc[1]),
    .RegWrite(RegWrite[1]), .RegDst(RegDst[1]), .MemParaReg(MemParaReg[1]),
    .ULAFonteA(ULAFonteA[1]), .ULAFonteB(ULAFonteB[1]), .ULAOp(ULAOp[1]),
    .EPCEsc(EPCEsc[1]), .ExcVetor(ExcVetor[1]), .state(st[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] pack(input int k);
    return {PCEsc[k], PCEscCond[k], PCFonte[k], CtrMem[k], IouD[k], IREsc[k],
            RegWrite[k], RegDst[k], MemParaReg[k], ULAFonteA[k], ULAFonteB[k],
            ULAOp[k], EPCEsc[k], ExcVetor[k]};
  endfunction

  // Reference output table, same field order as pack().
  function automatic logic [16:0] exp_out(input int s);
    logic pe, pc, cm, io, ir, rw, rd, mr, fa, ep, ev;
    logic [1:0] pf, fb, op;
    pe = 0; pc = 0; cm = 0; io = 0; ir = 0; rw = 0; rd = 0; mr = 0; fa = 0;
    ep = 0; ev = 0; pf = 2'b00; fb = 2'b00; op = 2'b11;
    case (s)
      2:  begin ir = 1; pe = 1; pf = 2'b00; fa = 0; fb = 2'b01; op = 2'b00; end
      3:  begin fa = 0; fb = 2'b11; op = 2'b00; end
      4:  begin fa = 1; fb = 2'b00; op = 2'b10; end
      5:  begin rw = 1; rd = 1; mr = 0; end
      6:  begin fa = 1; fb = 2'b10; op = 2'b00; end
      7:  begin rw = 1; rd = 0; end
      8:  io = 1;
      9:  io = 1;
      10: begin rw = 1; mr = 1; rd = 0; end
      11: begin io = 1; cm = 1; end
      12: begin fa = 1; fb = 2'b00; op = 2'b01; pc = 1; pf = 2'b01; end
      13: begin pe = 1; pf = 2'b10; end
      14: begin pe = 1; pf = 2'b11; end
`ifdef CONTROLADOR_EXC_EN
      15: begin ep = 1; pe = 1; ev = 1; end
`endif
      default: ;
    endcase
    return {pe, pc, pf, cm, io, ir, rw, rd, mr, fa, fb, op, ep, ev};
  endfunction

  // Push the expected per-cycle state trace of one instruction, ending in FETCH.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int m);
    expq.push_back(0);
    repeat (m) expq.push_back(1);
    expq.push_back(2);
    expq.push_back(3);
    case (op)
      6'b000000: if (fn == 6'b001000) expq.push_back(14);
                 else begin expq.push_back(4); expq.push_back(5); end
      6'b100011: begin
        expq.push_back(6); expq.push_back(8);
        repeat (m) expq.push_back(9);
        expq.push_back(10);
      end
      6'b101011: begin expq.push_back(6); expq.push_back(11); end
      6'b001000: begin expq.push_back(6); expq.push_back(7); end
      6'b000100: expq.push_back(12);
      6'b000010: expq.push_back(13);
      default: begin
`ifdef CONTROLADOR_EXC_EN
        expq.push_back(15);
`endif
      end
    endcase
    expq.push_back(0);
  endtask

  // Reset both instances, run one instruction on instance k, check every cycle.
  task automatic run(input string tag, input int k, input logic [5:0] op, input logic [5:0] fn);
    int e;
    int cyc;
    @(negedge Clock);
    Reset = 1'b0; OpCode = op; InstrArit = fn;
    @(negedge Clock);
    Reset = 1'b1;
    build(op, fn, (k == 0) ? 2 : 3);
    cyc = 0;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      chk($sformatf("%s.c%0d.state", tag, cyc), 32'(st[k]), 32'(e));
      chk($sformatf("%s.c%0d.outs", tag, cyc), 32'(pack(k)), 32'(exp_out(e)));
      cyc++;
      if (expq.size() > 0) begin
        @(posedge Clock);
        @(negedge Clock);
      end
    end
  endtask

  initial begin
    Reset = 1'b0; OpCode = 6'b000000; InstrArit = 6'b100000;
    #2;
    chk("reset.m2.state", 32'(st[0]), 32'd0);
    chk("reset.m2.outs", 32'(pack(0)), 32'(exp_out(0)));
    chk("reset.m3.state", 32'(st[1]), 32'd0);
    chk("reset.m3.outs", 32'(pack(1)), 32'(exp_out(0)));

    run("add_m2", 0, 6'b000000, 6'b100000);
    run("lw_m3", 1, 6'b100011, 6'b000000);
    run("lw_m2", 0, 6'b100011, 6'b000000);
    run("sw_m3", 1, 6'b101011, 6'b000000);
    run("beq_m2", 0, 6'b000100, 6'b000000);
    run("j_m3", 1, 6'b000010, 6'b000000);
    run("jr_m2", 0, 6'b000000, 6'b001000);
    run("addi_m3", 1, 6'b001000, 6'b000000);
    run("ill_m2", 0, 6'b111111, 6'b000000);
    run("ill_m3", 1, 6'b111111, 6'b000000);

    // Asynchronous reset in the middle of MWAIT (MEM_WAIT=3 instance).
    @(negedge Clock);
    Reset = 1'b0; OpCode = 6'b100011; InstrArit = 6'b000000;
    @(negedge Clock);
    Reset = 1'b1;
    repeat (9) begin
      @(posedge Clock);
      @(negedge Clock);
    end
    chk("areset.in_mwait", 32'(st[1]), 32'd9);
    #2;
    Reset = 1'b0;
    #1;
    chk("areset.state", 32'(st[1]), 32'd0);
    chk("areset.outs", 32'(pack(1)), 32'(exp_out(0)));
    // The full trace afterwards shows FWAIT counting from zero again.
    run("lw_after_areset", 1, 6'b100011, 6'b000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
